// File: rtl/radar_sim_pkg.sv
// Shared definitions for the azimuth pattern path: default geometry, word-count helper
// and the frame loader state encoding.
package radar_sim_pkg;

    localparam int unsigned SizeDefault  = 3200;
    localparam int unsigned WordWDefault = 32;

    // Number of stream words needed to cover a pattern of the given bit length.
    function automatic int unsigned words_for(input int unsigned size, input int unsigned word_w);
        return (size + word_w - 1) / word_w;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDrain,
        StFull
    } load_state_e;

endpackage

// File: rtl/azimuth_shadow_buffer.sv
// Shadow pattern register: word-addressed writes from the stream, full-width parallel read-out.
module azimuth_shadow_buffer
    import radar_sim_pkg::*;
#(
    parameter int unsigned SIZE   = SizeDefault,
    parameter int unsigned WORD_W = WordWDefault,
    parameter int unsigned IDX_W  = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [SIZE-1:0]   shadow_o
);

    logic [SIZE-1:0] shadow_q;

    // Bit-wise write so padding bits of the final word fall away naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else if (we_i) begin
            for (int unsigned b = 0; b < SIZE; b++) begin
                if (idx_i == IDX_W'(b / WORD_W)) begin
                    shadow_q[b] <= wdata_i[b % WORD_W];
                end
            end
        end
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/azimuth_frame_loader.sv
// Streams one azimuth pattern frame into a shadow buffer and swaps it onto the generator
// DATA bus at the next ARP rising edge, pulsing TRIG to restart the generator.
module azimuth_frame_loader
    import radar_sim_pkg::*;
#(
    parameter int unsigned SIZE   = SizeDefault,
    parameter int unsigned WORD_W = WordWDefault
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [WORD_W-1:0] s_tdata_i,
    input  logic              s_tvalid_i,
    output logic              s_tready_o,
    input  logic              s_tlast_i,
    input  logic              arp_i,
    output logic [SIZE-1:0]   data_o,
    output logic              trig_o,
    output logic              loaded_o,
    output logic              err_len_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int unsigned Words = words_for(SIZE, WORD_W);
    localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

    load_state_e     state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            arp_q;
    logic            loaded_q, loaded_d;
    logic            err_q, err_d;
    logic            active_valid_q;
    logic            trig_q;
    logic [15:0]     cnt_q;
    logic [SIZE-1:0] data_q;
    logic [SIZE-1:0] shadow;

    logic rise, accept, swap, we;

    assign rise       = arp_i & ~arp_q;
    assign s_tready_o = en_i & ((state_q == StFill) | (state_q == StDrain));
    assign accept     = s_tvalid_i & s_tready_o;
    assign swap       = en_i & (state_q == StFull) & rise;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        we       = 1'b0;
        if (!en_i) begin
            state_d  = StIdle;
            idx_d    = '0;
            loaded_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StFill;
                    idx_d   = '0;
                end
                StFill: begin
                    if (accept) begin
                        we = 1'b1;
                        if (idx_q == LastIdx) begin
                            if (s_tlast_i) begin
                                state_d  = StFull;
                                loaded_d = 1'b1;
                            end else begin
                                state_d = StDrain;
                                err_d   = 1'b1;
                            end
                        end else if (s_tlast_i) begin
                            // Short frame: restart collection from word 0.
                            err_d = 1'b1;
                            idx_d = '0;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (accept && s_tlast_i) begin
                        state_d  = StFull;
                        loaded_d = 1'b1;
                    end
                end
                StFull: begin
                    if (rise) begin
                        state_d  = StFill;
                        idx_d    = '0;
                        loaded_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            arp_q          <= 1'b0;
            loaded_q       <= 1'b0;
            err_q          <= 1'b0;
            active_valid_q <= 1'b0;
            trig_q         <= 1'b0;
            cnt_q          <= '0;
            data_q         <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            arp_q    <= arp_i;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            // A swap makes DATA valid in the same edge, so its own TRIG still fires.
            trig_q   <= en_i & rise & (active_valid_q | swap);
            if (swap) begin
                data_q         <= shadow;
                active_valid_q <= 1'b1;
                cnt_q          <= cnt_q + 16'd1;
            end
        end
    end

    azimuth_shadow_buffer #(
        .SIZE   (SIZE),
        .WORD_W (WORD_W),
        .IDX_W  (IdxW)
    ) u_shadow (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (we),
        .idx_i    (idx_q),
        .wdata_i  (s_tdata_i),
        .shadow_o (shadow)
    );

    assign data_o      = data_q;
    assign trig_o      = trig_q;
    assign loaded_o    = loaded_q;
    assign err_len_o   = err_q;
    assign frame_cnt_o = cnt_q;

endmodule

// File: doc/azimuth_frame_loader.md
Name: azimuth_frame_loader

Overview:
- Upstream stage of azimuth_signal_generator. Accepts one azimuth pattern frame as a stream of 32-bit words and assembles it in a shadow buffer.
- On the next azimuth rotation boundary (ARP), copies the shadow buffer to the generator's parallel DATA bus, then pulses TRIG so the generator restarts with the new pattern.
- Double-buffered: the host can stream the next frame while the current one plays.

Parameters:
- SIZE, 3200, pattern length in bits; equals the generator's SIZE.
- WORD_W, 32, stream word width.
- WORDS (localparam), ceil(SIZE/WORD_W) = 100, words per frame.

Ports:
- CLK  in  1  system clock; same clock as the generator.
- RST_N  in  1  reset, asynchronous, active-low.
- EN  in  1  block enable.
- S_TDATA  in  WORD_W  frame word; bit 0 is the lowest DATA index of that word.
- S_TVALID  in  1  word valid.
- S_TREADY  out  1  word accepted when S_TVALID & S_TREADY.
- S_TLAST  in  1  marks the final word of a frame.
- ARP  in  1  azimuth reset pulse (rotation boundary), synchronous to CLK, level ≥1 cycle.
- DATA  out  SIZE  active pattern to the generator.
- TRIG  out  1  one-cycle restart pulse to the generator.
- LOADED  out  1  shadow buffer holds a complete frame that has not yet been swapped.
- ERR_LEN  out  1  sticky frame-length error.
- FRAME_CNT  out  16  count of swaps performed; wraps at 65535→0.

Behaviour:
- Reset (RST_N=0, async): DATA=0, TRIG=0, S_TREADY=0, LOADED=0, ERR_LEN=0, FRAME_CNT=0, state=IDLE, word index=0, arp_q=0, active_valid=0.
- ARP edge detect: arp_q registered every cycle; rise = ARP & ~arp_q.
- FSM states:
  - IDLE: S_TREADY=0. Go to FILL when EN=1.
  - FILL: S_TREADY=1. Each accepted word k is written to shadow[k*WORD_W +: WORD_W]. In the last word, bits at index ≥SIZE are discarded.
    - Accept at k<WORDS-1 with S_TLAST=1 (short frame): set ERR_LEN, discard partial frame, index=0, stay in FILL.
    - Accept at k=WORDS-1 with S_TLAST=1: go to FULL, LOADED=1.
    - Accept at k=WORDS-1 with S_TLAST=0 (long frame): set ERR_LEN, go to DRAIN; the shadow contents are kept as valid.
  - DRAIN: S_TREADY=1. Words are discarded until one is accepted with S_TLAST=1, then go to FULL, LOADED=1.
  - FULL: S_TREADY=0. On rise: DATA<=shadow, LOADED<=0, active_valid<=1, FRAME_CNT++, index=0, go to FILL.
- Swap timing: rise sampled at edge n → DATA updated at edge n, TRIG=1 for the single cycle after edge n.
- TRIG pulses on every rise while EN=1 and active_valid=1, including rises with no pending frame (the old DATA replays). TRIG never lasts more than 1 cycle, even if ARP is held high.
- Simultaneous events:
  - Final word accepted in the same cycle as rise: no swap; the swap waits for the next rise.
  - If active_valid was 0 before that cycle, no TRIG is issued.
- EN=0 (sampled synchronously): state→IDLE, index=0, LOADED=0, TRIG=0, S_TREADY=0. DATA, active_valid, FRAME_CNT and ERR_LEN are retained. Any partial or pending frame is lost.
- ERR_LEN is cleared only by reset.
- Shadow buffer has no reset requirement; a reset value of 0 is permitted.

Decomposition:
- Shared package radar_sim_pkg holds SIZE and WORD_W defaults, the WORDS function (ceil-div), and the FSM state enum (IDLE, FILL, DRAIN, FULL).
- One sub-module is natural: azimuth_shadow_buffer, a word-addressed write into the SIZE-bit register with a parallel copy-out.

Test Plan:
- Basic load: SIZE=3200, stream 100 words 0x0000FFFF with TLAST on word 99, then pulse ARP.
  → DATA = 0x0000FFFF repeated across all words; TRIG high exactly 1 cycle after the ARP edge; FRAME_CNT=1; LOADED 1→0.
- Replay: a second ARP with no new frame → TRIG pulses, DATA unchanged, FRAME_CNT stays 1.
- Short frame: TLAST on word 49 → ERR_LEN=1, no LOADED. A following correct 100-word all-ones frame plus ARP → DATA all ones, FRAME_CNT=1.
- Long frame: 103 words with TLAST on word 102 → ERR_LEN=1; LOADED rises only after word 102; DATA after ARP equals words 0..99.
- Simultaneous event and backpressure: ARP rise in the same cycle as word 99 → no swap and no TRIG (active_valid=0). The next ARP swaps. S_TREADY=0 throughout FULL.
- Mid-frame disable and reset: EN low at word 40 → S_TREADY=0, LOADED=0, DATA retained. Re-enable and send a full frame → it loads from index 0. RST_N asserted mid-frame → all outputs 0 immediately (async).
